// File: rtl/rce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rce_pkg
// Description : Shared types and helpers for the ripple count extender.
// Revision    : 1.0 - initial release
// ============================================================================
package rce_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        TRACK = 1'b1
    } rce_state_e;

    // Mod-16 forward distance from the old nibble to the new one.
    function automatic logic [NIBBLE_W-1:0] nibble_delta(
        input logic [NIBBLE_W-1:0] new_v,
        input logic [NIBBLE_W-1:0] old_v
    );
        return new_v - old_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/count_settle_filter.sv
`default_nettype none
// ============================================================================
// Module      : count_settle_filter
// Description : Synchronizes the ripple counter nibble and accepts it once,
//               after it has held steady for STABLE_CYCLES clocks.
// Revision    : 1.0 - initial release
// ============================================================================
module count_settle_filter
    import rce_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NIBBLE_W-1:0] i_cnt,
    output logic [NIBBLE_W-1:0] o_s_value,
    output logic                o_accept
);

    localparam int RUN_W = 4;
    localparam logic [RUN_W-1:0] C_RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [SYNC_STAGES-1:0][NIBBLE_W-1:0] r_sync;
    logic [RUN_W-1:0]                     r_run;
    logic                                 r_done;

    logic [NIBBLE_W-1:0] w_s;
    logic [NIBBLE_W-1:0] w_s_next;
    logic                w_settled;
    logic                w_accept;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_s_next  = r_sync[SYNC_STAGES-2];
    assign w_settled = (r_run == C_RUN_MAX);
    assign w_accept  = w_settled && !r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_cnt};
        end
    end

    // The run restarts on the edge where a new value lands in the last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= '0;
            r_done <= 1'b0;
        end else if (w_s_next != w_s) begin
            r_run  <= '0;
            r_done <= 1'b0;
        end else begin
            if (!w_settled) begin
                r_run <= r_run + 1'b1;
            end
            if (w_accept) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_s_value = w_s;
    assign o_accept  = w_accept;

endmodule
`default_nettype wire

// File: rtl/ripple_count_extender.sv
`default_nettype none
// ============================================================================
// Module      : ripple_count_extender
// Description : Extends a settled 4-bit ripple count into a wide count with a
//               valid/ready output, wrap pulse and sticky status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ripple_count_extender
    import rce_pkg::*;
#(
    parameter int EXT_WIDTH     = 16,
    parameter int STABLE_CYCLES = 2,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           cnt_in,
    input  logic                 clr,
    input  logic                 out_ready,
    output logic [EXT_WIDTH-1:0] out_value,
    output logic                 out_valid,
    output logic                 wrap_pulse,
    output logic                 overflow,
    output logic                 missed
);

    rce_state_e          r_state;
    logic [NIBBLE_W-1:0] r_base;
    logic [EXT_WIDTH-1:0] r_value;
    logic                r_valid;
    logic                r_wrap;
    logic                r_ovf;
    logic                r_missed;

    logic [NIBBLE_W-1:0] w_s;
    logic                w_accept;
    logic [NIBBLE_W-1:0] w_delta;
    logic [EXT_WIDTH:0]  w_sum;
    logic                w_update;

    count_settle_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_filter (
        .clk       (clock),
        .rst_n     (reset),
        .i_cnt     (cnt_in),
        .o_s_value (w_s),
        .o_accept  (w_accept)
    );

    assign w_delta  = nibble_delta(w_s, r_base);
    assign w_sum    = {1'b0, r_value} + {{(EXT_WIDTH + 1 - NIBBLE_W){1'b0}}, w_delta};
    assign w_update = w_accept && (r_state == TRACK) && (w_delta != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= INIT;
            r_base   <= '0;
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_ovf    <= 1'b0;
            r_missed <= 1'b0;
        end else if (clr) begin
            r_state  <= INIT;
            r_value  <= '0;
            r_valid  <= 1'b0;
            r_wrap   <= 1'b0;
            r_ovf    <= 1'b0;
            r_missed <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_accept && (r_state == INIT)) begin
                r_base  <= w_s;
                r_state <= TRACK;
            end
            // A fresh update keeps out_valid high even in a transfer cycle.
            if (w_update) begin
                r_value <= w_sum[EXT_WIDTH-1:0];
                r_valid <= 1'b1;
                r_base  <= w_s;
                r_wrap  <= (w_s < r_base);
                if (w_sum[EXT_WIDTH]) begin
                    r_ovf <= 1'b1;
                end
                if (r_valid && !out_ready) begin
                    r_missed <= 1'b1;
                end
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_value  = r_value;
    assign out_valid  = r_valid;
    assign wrap_pulse = r_wrap;
    assign overflow   = r_ovf;
    assign missed     = r_missed;

endmodule
`default_nettype wire

// File: doc/ripple_count_extender.md
Name: ripple_count_extender

Overview:
- Downstream consumer of the 4-bit JK ripple counter output.
- Takes the counter's asynchronous, momentarily-glitchy q[3:0] into the system clock domain and waits for the value to settle.
- Converts each settled value into a modulo-16 increment and accumulates it into a wide synchronous count.
- Presents that count through a valid/ready handshake to downstream logic, together with a wrap pulse and a sticky overflow flag.

Parameters:
EXT_WIDTH, 16, width of extended count output (min 5)
STABLE_CYCLES, 2, consecutive equal synchronized samples required before a value is accepted (1..15)
SYNC_STAGES, 2, flip-flop depth of input synchronizer (2..3)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset (0 = reset)
cnt_in  input  4  ripple counter q[3:0], asynchronous to clock
clr  input  1  synchronous clear of count and flags
out_ready  input  1  downstream accepts out_value when high with out_valid
out_value  output  EXT_WIDTH  extended count
out_valid  output  1  out_value holds an unconsumed update
wrap_pulse  output  1  one-cycle pulse when accepted low nibble wraps past 15
overflow  output  1  sticky: extended count wrapped past 2^EXT_WIDTH-1
missed  output  1  sticky: an update replaced an unconsumed one

Behaviour:
- Reset (reset=0, async) clears all outputs, synchronizer, filter, baseline and FSM:
  - out_value=0, out_valid=0, wrap_pulse=0, overflow=0, missed=0
  - FSM enters INIT.
- Synchronizer: SYNC_STAGES flops on each bit of cnt_in. Output is called s.
- Settle filter:
  - Counter run increments when s equals the previous s, saturating at STABLE_CYCLES.
  - Counter reloads to 0 when s changes.
  - "settled" is asserted when run == STABLE_CYCLES.
  - Value is accepted on the first cycle settled is high for a given run. It is not re-accepted while s stays unchanged.
- FSM:
  - INIT: the first accepted value is loaded as baseline. No count change, no out_valid. Go to TRACK.
  - TRACK: on accept, delta = (new - baseline) mod 16, 4-bit unsigned.
    - delta=0: no action.
    - delta>0: out_value += zero-extended delta (mod 2^EXT_WIDTH); baseline = new.
- wrap_pulse: asserted for one cycle when new < old baseline (nibble wrapped), in the cycle after accept.
- overflow: set when the addition carries out of EXT_WIDTH. Cleared only by reset or clr.
- Latency: cnt_in change to out_valid rise = SYNC_STAGES + STABLE_CYCLES + 1 clocks (nominal 5).
- Handshake:
  - out_valid rises with each out_value update.
  - Transfer occurs on a cycle where out_valid && out_ready; out_valid falls next cycle unless a new update lands in that same cycle, in which case out_valid stays high.
  - out_value is stable while out_valid && !out_ready, except when a new update arrives. Then the value updates (coalescing increments) and missed is set sticky.
- clr:
  - Clears out_value, out_valid, overflow and missed.
  - Returns FSM to INIT, so the next settled value becomes the new baseline.
  - Takes priority over a simultaneous accept, which is discarded.
- Reset mid-operation: immediate async return to reset state. Synchronizer contents are discarded.
- Increments of 16 or more between accepts alias mod 16. This is a documented limitation: the ripple clock must be slow enough relative to clock.

Decomposition:
- Package rce_pkg:
  - FSM state enum {INIT, TRACK}
  - constant NIBBLE_W=4
  - function nibble_delta(new, old) returning a 4-bit mod-16 difference
- One natural sub-module: count_settle_filter. It contains the synchronizer plus the run-length filter, with outputs s_value[3:0] and accept.
- Top level contains the FSM, accumulator and handshake.

Test Plan:
- Reset hold, then cnt_in=3 held 10 clocks -> baseline=3, out_valid stays 0, out_value=0.
- From baseline 3, cnt_in 3→4→5, each held 8 clocks, out_ready=1 -> out_value 1 then 2, out_valid one-cycle pulses, each 5 clocks after its change.
- Baseline 14, cnt_in→1 held -> delta=3, out_value+=3, wrap_pulse single cycle.
- out_ready=0, two updates of +1 each -> out_value=2 after second, missed=1, out_valid held high. Then out_ready=1 -> out_valid drops the next clock.
- cnt_in glitch 5→7 for 1 clock then back to 5, STABLE_CYCLES=2 -> no accept, out_value unchanged.
- EXT_WIDTH=5, out_value=30, delta=3 -> out_value=1, overflow=1. clr -> out_value=0, overflow=0, FSM to INIT.
